slsd_ram_scheduler: RTL and testbench



---
 rtl/slsd_ram_scheduler_if.sv | 34 +++
 rtl/slsd_ram_scheduler.sv | 169 ++++++++++++++++
 tb/tb_slsd_ram_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slsd_ram_scheduler_if.sv
// rtl/slsd_ram_scheduler_if.sv - detector write, reader drain and segment RAM port bundle
interface slsd_ram_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 4096,
  localparam int COUNT_BITW = $clog2(RAM_SIZE)
);
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;

  logic                  rd_req;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  logic                  ram_en;
  logic                  ram_we;
  logic [COUNT_BITW-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    input  wr_req, wr_data, rd_req, ram_rdata,
    output wr_ack, rd_ack, rd_valid, rd_data, rd_last,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output wr_req, wr_data, rd_req, ram_rdata,
    input  wr_ack, rd_ack, rd_valid, rd_data, rd_last,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/slsd_ram_scheduler.sv
// rtl/slsd_ram_scheduler.sv - per-frame fill/drain sequencer for the LSD segment RAM
// SLSD_RAM_SCHED_STATS_EN enables the drop_count and peak_count statistics.
module slsd_ram_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 4096,
  localparam int COUNT_BITW = $clog2(RAM_SIZE)
) (
  input  logic                  clock,
  input  logic                  n_rst,
  input  logic                  frame_start,
  input  logic                  frame_end,
  slsd_ram_scheduler_if.master  bus,
  output logic                  drain_done,
  output logic                  mem_flag,
  output logic                  mem_valid,
  output logic [COUNT_BITW:0]   seg_count,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [COUNT_BITW:0]   peak_count
);

  localparam logic [COUNT_BITW:0] FULL_COUNT = (COUNT_BITW+1)'(RAM_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [COUNT_BITW:0] rd_ptr;
  logic [COUNT_BITW:0] fill_total;
  logic                wr_commit;
  logic                wr_drop;
  logic                fill_end;
  logic                last_done;
  logic                rd_p1;
  logic                rd_p1_last;
  logic                rd_p2;
  logic                rd_p2_last;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (frame_start) next_state = FILL;
      end
      FILL: begin
        if (frame_start) begin
          next_state = FILL;
        end else if (frame_end) begin
          next_state = (fill_total == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (frame_start) begin
          next_state = FILL;
        end else if (last_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A frame_start cycle belongs to the new frame, so neither handshake completes in it.
  always_comb begin
    bus.wr_ack = (state == FILL) && bus.wr_req && !frame_start;
    bus.rd_ack = (state == DRAIN) && bus.rd_req && (rd_ptr < seg_count) && !frame_start;
    wr_commit  = bus.wr_ack && (seg_count < FULL_COUNT);
    wr_drop    = bus.wr_ack && !(seg_count < FULL_COUNT);
    fill_total = seg_count + (COUNT_BITW+1)'(wr_commit);
    fill_end   = (state == FILL) && frame_end && !frame_start;
    last_done  = (state == DRAIN) && bus.rd_valid && bus.rd_last;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      mem_flag      <= 1'b0;
      mem_valid     <= 1'b0;
      seg_count     <= '0;
      overflow      <= 1'b0;
      rd_ptr        <= '0;
    end else begin
      bus.ram_en <= wr_commit || bus.rd_ack;
      bus.ram_we <= wr_commit;
      if (wr_commit) begin
        bus.ram_addr  <= seg_count[COUNT_BITW-1:0];
        bus.ram_wdata <= bus.wr_data;
      end else if (bus.rd_ack) begin
        bus.ram_addr <= rd_ptr[COUNT_BITW-1:0];
      end
      mem_flag  <= (state == FILL);
      mem_valid <= wr_commit;
      if (frame_start) begin
        seg_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (wr_commit) seg_count <= seg_count + 1'b1;
        if (wr_drop)   overflow  <= 1'b1;
      end
      if (frame_start || fill_end) begin
        rd_ptr <= '0;
      end else if (bus.rd_ack) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Read return pipeline: address out, RAM latency, then registered data. A restart
  // flushes every stage so stale words from the old frame never surface.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      rd_p1        <= 1'b0;
      rd_p1_last   <= 1'b0;
      rd_p2        <= 1'b0;
      rd_p2_last   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_last  <= 1'b0;
      drain_done   <= 1'b0;
    end else begin
      rd_p1        <= bus.rd_ack;
      rd_p1_last   <= (rd_ptr == seg_count - 1'b1);
      rd_p2        <= rd_p1 && !frame_start;
      rd_p2_last   <= rd_p1_last;
      bus.rd_valid <= rd_p2 && !frame_start;
      bus.rd_last  <= rd_p2 && rd_p2_last && !frame_start;
      if (rd_p2) bus.rd_data <= bus.ram_rdata;
      drain_done <= (fill_end && (fill_total == '0)) || (last_done && !frame_start);
    end
  end

`ifdef SLSD_RAM_SCHED_STATS_EN
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      drop_count <= '0;
      peak_count <= '0;
    end else begin
      if (frame_start) begin
        drop_count <= '0;
      end else if (wr_drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (wr_commit && ((seg_count + 1'b1) > peak_count)) begin
        peak_count <= seg_count + 1'b1;
      end
    end
  end
`else
  assign drop_count = '0;
  assign peak_count = '0;
`endif

endmodule

// File: tb/tb_slsd_ram_scheduler.sv
// tb/tb_slsd_ram_scheduler.sv - directed and randomized check of slsd_ram_scheduler against a frame-level model
module tb_slsd_ram_scheduler;
  localparam int DW = 32;
  localparam int RS = 8;
  localparam int CB = $clog2(RS);

  logic          clock = 1'b0;
  logic          n_rst;
  logic          frame_start;
  logic          frame_end;
  logic          drain_done;
  logic          mem_flag;
  logic          mem_valid;
  logic [CB:0]   seg_count;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [CB:0]   peak_count;

  slsd_ram_scheduler_if #(.DATA_WIDTH(DW), .RAM_SIZE(RS)) bus ();

  slsd_ram_scheduler #(.DATA_WIDTH(DW), .RAM_SIZE(RS)) dut (
    .clock       (clock),
    .n_rst       (n_rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .bus         (bus),
    .drain_done  (drain_done),
    .mem_flag    (mem_flag),
    .mem_valid   (mem_valid),
    .seg_count   (seg_count),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .peak_count  (peak_count)
  );

  always #5 clock = ~clock;

  // Single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram [RS];
  always @(posedge clock) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= ram[bus.ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Frame-level model: phase 0 idle, 1 fill, 2 drain; reads return at a timestamp.
  int            m_phase = 0;
  int            m_cnt   = 0;
  int            m_drops = 0;
  int            m_peak  = 0;
  int            m_rnext = 0;
  bit            m_ovf   = 0;
  logic [DW-1:0] m_store [RS];
  int            q_due [$];
  int            q_idx [$];
  bit            e_en = 0, e_we = 0, e_mv = 0, e_flag = 0, e_dd = 0;
  logic [CB-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  int            mv_cnt, dd_cnt, dd_cyc, last_rv, first_ack, first_rv;
  int            wa_log [$];
  logic [DW-1:0] rv_log [$];
  bit            rl_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      m_phase = 0; m_cnt = 0; m_ovf = 0; m_drops = 0; m_peak = 0; m_rnext = 0;
      q_due.delete(); q_idx.delete();
      e_en = 0; e_we = 0; e_mv = 0; e_flag = 0; e_dd = 0; e_addr = '0; e_wdata = '0;
    end else begin
      bit acc_w, acc_r, rv_now, last_now;
      acc_w    = (m_phase == 1) && bus.wr_req && !frame_start;
      acc_r    = (m_phase == 2) && bus.rd_req && (m_rnext < m_cnt) && !frame_start;
      rv_now   = (q_due.size() != 0) && (q_due[0] == cyc);
      last_now = rv_now && (q_idx[0] == m_cnt - 1);
      if (rv_now) begin
        void'(q_due.pop_front());
        void'(q_idx.pop_front());
      end
      e_en = 0; e_we = 0; e_mv = 0; e_dd = 0;
      e_flag = (m_phase == 1);
      if (frame_start) begin
        m_phase = 1; m_cnt = 0; m_ovf = 0; m_drops = 0; m_rnext = 0;
        q_due.delete(); q_idx.delete();
      end else begin
        if (acc_w) begin
          if (m_cnt < RS) begin
            m_store[m_cnt] = bus.wr_data;
            e_en = 1; e_we = 1; e_addr = m_cnt[CB-1:0]; e_wdata = bus.wr_data; e_mv = 1;
            m_cnt++;
            if (m_cnt > m_peak) m_peak = m_cnt;
          end else begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
          end
        end
        if ((m_phase == 1) && frame_end) begin
          if (m_cnt == 0) begin
            m_phase = 0; e_dd = 1;
          end else begin
            m_phase = 2; m_rnext = 0;
          end
        end else if ((m_phase == 2) && last_now) begin
          m_phase = 0; e_dd = 1;
        end
        if (acc_r) begin
          e_en = 1; e_we = 0; e_addr = m_rnext[CB-1:0];
          q_due.push_back(cyc + 3);
          q_idx.push_back(m_rnext);
          m_rnext++;
        end
      end
      cyc++;
    end
  end

  always @(negedge clock) begin
    if (n_rst) begin
      bit rv_e;
      rv_e = (q_due.size() != 0) && (q_due[0] == cyc);
      chk("wr_ack", bus.wr_ack, (m_phase == 1) && bus.wr_req && !frame_start);
      chk("rd_ack", bus.rd_ack, (m_phase == 2) && bus.rd_req && (m_rnext < m_cnt) && !frame_start);
      chk("ram_en", bus.ram_en, e_en);
      chk("ram_we", bus.ram_we, e_we);
      if (e_en) chk("ram_addr", bus.ram_addr, e_addr);
      if (e_we) chk("ram_wdata", bus.ram_wdata, e_wdata);
      chk("mem_flag", mem_flag, e_flag);
      chk("mem_valid", mem_valid, e_mv);
      chk("seg_count", seg_count, m_cnt);
      chk("overflow", overflow, m_ovf);
`ifdef SLSD_RAM_SCHED_STATS_EN
      chk("drop_count", drop_count, m_drops);
      chk("peak_count", peak_count, m_peak);
`else
      chk("drop_count", drop_count, 0);
      chk("peak_count", peak_count, 0);
`endif
      chk("rd_valid", bus.rd_valid, rv_e);
      if (rv_e) begin
        chk("rd_data", bus.rd_data, m_store[q_idx[0]]);
        chk("rd_last", bus.rd_last, q_idx[0] == m_cnt - 1);
      end
      chk("drain_done", drain_done, e_dd);
      if (bus.ram_en && bus.ram_we) wa_log.push_back(int'(bus.ram_addr));
      if (mem_valid) mv_cnt++;
      if (bus.rd_ack && first_ack < 0) first_ack = cyc;
      if (bus.rd_valid) begin
        rv_log.push_back(bus.rd_data);
        rl_log.push_back(bus.rd_last);
        last_rv = cyc;
        if (first_rv < 0) first_rv = cyc;
      end
      if (drain_done) begin
        dd_cnt++;
        dd_cyc = cyc;
      end
    end
  end

  task automatic clear_logs();
    mv_cnt = 0; dd_cnt = 0; dd_cyc = -1; last_rv = -1; first_ack = -1; first_rv = -1;
    wa_log.delete(); rv_log.delete(); rl_log.delete();
  endtask

  task automatic step(input bit s, input bit e, input bit w, input logic [DW-1:0] d, input bit r);
    frame_start = s; frame_end = e; bus.wr_req = w; bus.wr_data = d; bus.rd_req = r;
    @(posedge clock);
    #1;
  endtask

  task automatic drain_wait(input int budget);
    int n;
    n = 0;
    while (dd_cnt == 0 && n < budget) begin
      step(0, 0, 0, '0, 1);
      n++;
    end
    chk("drain_timeout", dd_cnt != 0, 1);
  endtask

  logic [DW-1:0] d4;

  initial begin
    n_rst = 1'b0; frame_start = 0; frame_end = 0;
    bus.wr_req = 1; bus.wr_data = '0; bus.rd_req = 1;
    clear_logs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_rd_ack", bus.rd_ack, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_seg_count", seg_count, 0);
    chk("rst_mem_flag", mem_flag, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_peak", peak_count, 0);
    @(negedge clock);
    n_rst = 1'b1; bus.wr_req = 0; bus.rd_req = 0;
    @(posedge clock);
    #1;

    // Five writes, separate frame_end, continuous reads.
    clear_logs();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hD000_0000 + i, 0);
    step(0, 1, 0, '0, 0);
    drain_wait(40);
    chk("s1_mv_pulses", mv_cnt, 5);
    chk("s1_wr_count", wa_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("s1_wr_addr", wa_log[i], i);
    chk("s1_seg_count", seg_count, 5);
    chk("s1_rd_count", rv_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("s1_rd_data", rv_log[i], 32'hD000_0000 + i);
      chk("s1_rd_last", rl_log[i], i == 4);
    end
    chk("s1_rd_latency", first_rv - first_ack, 3);
    chk("s1_done_after_last", dd_cyc - last_rv, 1);

    // Eleven writes into an eight-deep RAM.
    clear_logs();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 1, $urandom, 0);
    step(0, 1, 0, '0, 0);
    drain_wait(40);
    chk("s2_seg_count", seg_count, 8);
    chk("s2_overflow", overflow, 1);
`ifdef SLSD_RAM_SCHED_STATS_EN
    chk("s2_drop_count", drop_count, 3);
    chk("s2_peak_count", peak_count, 8);
`else
    chk("s2_drop_count", drop_count, 0);
    chk("s2_peak_count", peak_count, 0);
`endif
    chk("s2_mv_pulses", mv_cnt, 8);
    chk("s2_rd_count", rv_log.size(), 8);
    chk("s2_rd_last", rl_log[7], 1);

    // Empty frame.
    clear_logs();
    step(1, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    repeat (3) step(0, 0, 1, '0, 1);
    chk("s3_drain_done", dd_cnt, 1);
    chk("s3_rd_count", rv_log.size(), 0);
    chk("s3_wr_ack_idle", bus.wr_ack, 0);

    // Write coinciding with frame_end.
    clear_logs();
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 32'hA1, 0);
    step(0, 0, 1, 32'hA2, 0);
    step(0, 1, 1, 32'hA3, 0);
    drain_wait(40);
    chk("s4_seg_count", seg_count, 3);
    chk("s4_rd_count", rv_log.size(), 3);
    d4 = 32'hA3;
    chk("s4_third_word", rv_log[2], d4);

    // Restart during drain with two reads in flight.
    clear_logs();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hB0 + i, 0);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    for (int n = 0; n < 10 && rv_log.size() == 0; n++) step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(1, 0, 0, '0, 0);
    repeat (8) step(0, 0, 0, '0, 1);
    chk("s5_rd_count", rv_log.size(), 1);
    chk("s5_no_drain_done", dd_cnt, 0);
    chk("s5_seg_count", seg_count, 0);
    chk("s5_mem_flag", mem_flag, 1);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);

    // Asynchronous reset in the middle of a fill.
    clear_logs();
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hC0 + i, 0);
    bus.wr_req = 1;
    n_rst = 1'b0;
    #1;
    chk("s6_seg_count", seg_count, 0);
    chk("s6_mem_flag", mem_flag, 0);
    chk("s6_mem_valid", mem_valid, 0);
    chk("s6_ram_en", bus.ram_en, 0);
    chk("s6_wr_ack", bus.wr_ack, 0);
    @(negedge clock);
    n_rst = 1'b1;
    @(posedge clock);
    #1;
    repeat (3) step(0, 0, 1, 32'hEE, 0);
    chk("s6_wr_ack_after", bus.wr_ack, 0);
    chk("s6_peak_cleared", peak_count, 0);

    // Randomized frames, biased by the model's phase.
    for (int i = 0; i < 3000; i++) begin
      bit s, e, w, r;
      case (m_phase)
        1: begin
          s = ($urandom % 50) == 0;
          e = ($urandom % 10) == 0;
          w = s ? 1'b0 : (($urandom % 10) < 6);
          r = $urandom % 2;
        end
        2: begin
          s = ($urandom % 60) == 0;
          e = ($urandom % 8) == 0;
          w = $urandom % 2;
          r = s ? 1'b0 : (($urandom % 10) < 7);
        end
        default: begin
          s = ($urandom % 4) == 0;
          e = ($urandom % 8) == 0;
          w = $urandom % 2;
          r = $urandom % 2;
        end
      endcase
      step(s, e, w, $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
